// File: rtl/class_vote_filter.sv
// class_vote_filter: sliding-window majority vote over per-frame class decisions.
// Optional feature: define VOTE_CHANGE_ONLY_EN to issue decisions only when the class changes.
module class_vote_filter #(
    parameter int NUM_CLASSES   = 10,
    parameter int HISTORY_DEPTH = 8,
    parameter int MIN_VOTES     = 3
) (
    input  logic                               clk_i,
    input  logic                               reset_ni,
    input  logic [$clog2(NUM_CLASSES)-1:0]     class_i,
    input  logic                               inp_valid_i,
    input  logic                               clear_i,
    output logic [$clog2(NUM_CLASSES)-1:0]     class_o,
    output logic [$clog2(HISTORY_DEPTH+1)-1:0] votes_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [7:0]                         overrun_o
);

    localparam int CW = $clog2(NUM_CLASSES);
    localparam int VW = $clog2(HISTORY_DEPTH + 1);
    localparam int PW = (HISTORY_DEPTH > 1) ? $clog2(HISTORY_DEPTH) : 1;
    localparam logic [CW:0] NC = (CW + 1)'(NUM_CLASSES);

    logic [CW-1:0] hist [HISTORY_DEPTH];
    logic [PW-1:0] wptr;
    logic [VW-1:0] fill;
    logic [VW-1:0] cnt [NUM_CLASSES];
    logic [VW-1:0] cnt_nxt [NUM_CLASSES];
    logic          pend;
    logic          full;
    logic          accept;
    logic [VW-1:0] best_cnt;
    logic [CW-1:0] best_idx;
    logic          change_ok;
    logic          new_dec;

    assign full   = (fill == VW'(HISTORY_DEPTH));
    assign accept = inp_valid_i && !clear_i && ({1'b0, class_i} < NC);

    // Per-class counter update: +1 for the new class, -1 for the evicted one.
    always_comb begin
        for (int i = 0; i < NUM_CLASSES; i++) begin
            cnt_nxt[i] = cnt[i];
            if (class_i == CW'(i) && !(full && hist[wptr] == CW'(i)))
                cnt_nxt[i] = cnt[i] + VW'(1);
            else if (class_i != CW'(i) && full && hist[wptr] == CW'(i))
                cnt_nxt[i] = cnt[i] - VW'(1);
        end
    end

    // Winner search over registered counters; strict compare keeps lowest index on ties.
    always_comb begin
        best_cnt = '0;
        best_idx = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (cnt[i] > best_cnt) begin
                best_cnt = cnt[i];
                best_idx = CW'(i);
            end
        end
    end

    // History ring, fill level, vote counters and evaluation flag.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < HISTORY_DEPTH; i++) hist[i] <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
            wptr <= '0;
            fill <= '0;
            pend <= 1'b0;
        end else if (clear_i) begin
            for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
            wptr <= '0;
            fill <= '0;
            pend <= 1'b0;
        end else begin
            pend <= accept;
            if (accept) begin
                hist[wptr] <= class_i;
                for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= cnt_nxt[i];
                if (wptr == PW'(HISTORY_DEPTH - 1)) wptr <= '0;
                else wptr <= wptr + PW'(1);
                if (!full) fill <= fill + VW'(1);
            end
        end
    end

`ifdef VOTE_CHANGE_ONLY_EN
    logic          last_v;
    logic [CW-1:0] last_cls;

    // Remember the last issued class so repeats can be suppressed.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            last_v   <= 1'b0;
            last_cls <= '0;
        end else if (clear_i) begin
            last_v   <= 1'b0;
        end else if (new_dec) begin
            last_v   <= 1'b1;
            last_cls <= best_idx;
        end
    end

    assign change_ok = !last_v || (last_cls != best_idx);
`else
    assign change_ok = 1'b1;
`endif

    assign new_dec = pend && !clear_i && change_ok
                     && (best_cnt >= VW'(MIN_VOTES));

    // Output holding register with overwrite accounting.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            class_o     <= '0;
            votes_o     <= '0;
            out_valid_o <= 1'b0;
            overrun_o   <= '0;
        end else if (new_dec) begin
            class_o     <= best_idx;
            votes_o     <= best_cnt;
            out_valid_o <= 1'b1;
            if (out_valid_o && !out_ready_i && overrun_o != 8'hFF)
                overrun_o <= overrun_o + 8'd1;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_class_vote_filter.sv
// tb_class_vote_filter: directed scenarios plus random traffic for class_vote_filter,
// checked every cycle against a window/queue model of the voting rules.
module tb_class_vote_filter;

    localparam int NC = 10;
    localparam int HD = 8;
    localparam int MV = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] cls = '0;
    logic       valid = 1'b0;
    logic       clear = 1'b0;
    logic       ready = 1'b1;
    logic [3:0] o_cls;
    logic [3:0] o_votes;
    logic       o_valid;
    logic [7:0] o_ovr;

    int n_assert = 0;
    int n_fail = 0;
    bit started = 0;

    class_vote_filter #(
        .NUM_CLASSES(NC),
        .HISTORY_DEPTH(HD),
        .MIN_VOTES(MV)
    ) dut (
        .clk_i(clk),
        .reset_ni(rst_n),
        .class_i(cls),
        .inp_valid_i(valid),
        .clear_i(clear),
        .class_o(o_cls),
        .votes_o(o_votes),
        .out_valid_o(o_valid),
        .out_ready_i(ready),
        .overrun_o(o_ovr)
    );

    always #5 clk = ~clk;

    // ---- reference model: window as a queue, winner by counting ----
    int   q[$];
    bit   pend = 0;
    bit   ev = 0;
    int   ecls = 0;
    int   evotes = 0;
    int   eovr = 0;
    bit   lastv = 0;
    int   lastc = 0;
    logic [7:0] dq[$];

    function automatic void winner(output int w, output int wc);
        int c[NC];
        foreach (c[i]) c[i] = 0;
        foreach (q[k]) c[q[k]]++;
        w = 0;
        wc = 0;
        for (int i = 0; i < NC; i++)
            if (c[i] > wc) begin
                wc = c[i];
                w = i;
            end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int  w, wc;
        bit  dec, acc;
        if (!rst_n) begin
            q.delete();
            pend = 0; ev = 0; ecls = 0; evotes = 0; eovr = 0;
            lastv = 0; lastc = 0;
        end else begin
            winner(w, wc);
            dec = pend && !clear && wc >= MV;
`ifdef VOTE_CHANGE_ONLY_EN
            dec = dec && !(lastv && lastc == w);
`endif
            if (clear) lastv = 0;
            if (dec) begin
                if (ev && !ready && eovr < 255) eovr++;
                ev = 1; ecls = w; evotes = wc;
                lastv = 1; lastc = w;
            end else if (ev && ready) begin
                ev = 0;
            end
            acc = valid && !clear && int'(cls) < NC;
            if (clear) q.delete();
            else if (acc) begin
                q.push_back(int'(cls));
                if (q.size() > HD) void'(q.pop_front());
            end
            pend = acc;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---- cycle compare against the model ----
    always @(negedge clk) begin
        if (started) begin
            chk("valid", int'(o_valid), int'(ev));
            chk("class", int'(o_cls), ecls);
            chk("votes", int'(o_votes), evotes);
            chk("overrun", int'(o_ovr), eovr);
            if (o_valid && ready) dq.push_back({o_cls, o_votes});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int c);
        cls = 4'(c);
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic chk_entry(input string nm, input int idx, input int c, input int v);
        if (idx < dq.size()) begin
            chk({nm, "_cls"}, int'(dq[idx][7:4]), c);
            chk({nm, "_votes"}, int'(dq[idx][3:0]), v);
        end else begin
            chk({nm, "_present"}, 0, 1);
        end
    endtask

    initial begin
        int sz;
        #1 rst_n = 1'b0;
        started = 1;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_ovr", int'(o_ovr), 0);

        // Three equal inputs: decision two cycles after the third
        ready = 1'b1;
        feed(4); feed(4); feed(4);
        chk("lat_not_yet", int'(o_valid), 0);
        step();
        chk("lat_valid", int'(o_valid), 1);
        chk("lat_class", int'(o_cls), 4);
        chk("lat_votes", int'(o_votes), 3);
        step(); step();

        // Sliding window: 8x class 2 then 5x class 7
        do_clear();
        step(); step();
        dq.delete();
        for (int i = 0; i < 8; i++) feed(2);
        for (int i = 0; i < 5; i++) feed(7);
        step(); step(); step();
`ifdef VOTE_CHANGE_ONLY_EN
        chk("win_count", dq.size(), 2);
        chk_entry("win0", 0, 2, 3);
        chk_entry("win1", 1, 7, 5);
`else
        chk("win_count", dq.size(), 11);
        chk_entry("win6", 6, 2, 7);
        chk_entry("win7", 7, 2, 6);
        chk_entry("win8", 8, 2, 5);
        chk_entry("win9", 9, 2, 4);
        chk_entry("win10", 10, 7, 5);
`endif

        // Tie: 4x class 1, 4x class 6 -> lowest index wins
        do_clear();
        step(); step();
        dq.delete();
        for (int i = 0; i < 4; i++) feed(1);
        for (int i = 0; i < 4; i++) feed(6);
        step(); step(); step();
`ifdef VOTE_CHANGE_ONLY_EN
        chk("tie_count", dq.size(), 1);
        chk_entry("tie", 0, 1, 3);
`else
        chk_entry("tie", dq.size() - 1, 1, 4);
`endif

        // Back-pressure and overrun
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) feed(8);
        step(); step();
        chk("bp_valid", int'(o_valid), 1);
        chk("bp_class", int'(o_cls), 8);
`ifdef VOTE_CHANGE_ONLY_EN
        chk("bp_votes", int'(o_votes), 3);
        chk("bp_ovr", int'(o_ovr), 0);
`else
        chk("bp_votes", int'(o_votes), 5);
        chk("bp_ovr", int'(o_ovr), 2);
`endif
        ready = 1'b1;
        step();
        chk("bp_drop", int'(o_valid), 0);

        // Clear with simultaneous input cancels in-flight decision
        do_reset();
        dq.delete();
        for (int i = 0; i < 5; i++) feed(3);
        clear = 1'b1;
        feed(3);
        clear = 1'b0;
        step(); step(); step();
`ifdef VOTE_CHANGE_ONLY_EN
        chk("clr_before", dq.size(), 1);
`else
        chk("clr_before", dq.size(), 2);
`endif
        sz = dq.size();
        feed(12); feed(12); feed(15);
        feed(3); feed(3);
        step(); step(); step();
        chk("clr_none", dq.size(), sz);
        feed(3);
        step(); step(); step();
        chk("clr_after", dq.size(), sz + 1);
        chk_entry("clr_new", sz, 3, 3);

        // Ten of class 5, then async reset mid-stream
        do_reset();
        dq.delete();
        for (int i = 0; i < 10; i++) feed(5);
        step(); step(); step();
`ifdef VOTE_CHANGE_ONLY_EN
        chk("five_count", dq.size(), 1);
`else
        chk("five_count", dq.size(), 8);
`endif
        ready = 1'b0;
        for (int i = 0; i < 4; i++) feed(6);
        cls = 4'd6;
        valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(o_valid), 0);
        chk("arst_class", int'(o_cls), 0);
        chk("arst_votes", int'(o_votes), 0);
        chk("arst_ovr", int'(o_ovr), 0);
        valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        ready = 1'b1;
        dq.delete();
        feed(5); feed(5);
        step(); step(); step();
        chk("post_rst_none", dq.size(), 0);
        feed(5);
        step(); step(); step();
        chk("post_rst_one", dq.size(), 1);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            valid = ($urandom_range(0, 9) < 7);
            cls = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3))
                                             : 4'($urandom_range(0, 15));
            ready = ($urandom_range(0, 2) != 0);
            clear = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 999) < 3) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
                #0;
            end
            step();
        end
        valid = 1'b0;
        clear = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/class_vote_filter.md
CLASS_VOTE_FILTER -- requirements
Module: class_vote_filter

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10, number of classifier classes.
REQ-002 SHALL have parameter HISTORY_DEPTH, default 8, number of past decisions held in the vote window.
REQ-003 SHALL have parameter MIN_VOTES, default 3, minimum winner count needed to emit a decision.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_ni  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port class_i  input  $clog2(NUM_CLASSES)  per-frame class index from the upstream accumulator/argmax stage.
REQ-007 SHALL have port inp_valid_i  input  1  class_i valid, single-cycle pulse per frame; the block is always ready.
REQ-008 SHALL have port clear_i  input  1  synchronous flush of the history window.
REQ-009 SHALL have port class_o  output  $clog2(NUM_CLASSES)  filtered (majority) class.
REQ-010 SHALL have port votes_o  output  $clog2(HISTORY_DEPTH+1)  vote count of class_o in the window.
REQ-011 SHALL have port out_valid_o  output  1  class_o/votes_o valid.
REQ-012 SHALL have port out_ready_i  input  1  downstream accept; a transfer occurs when out_valid_o && out_ready_i.
REQ-013 SHALL have port overrun_o  output  8  saturating count of undelivered decisions overwritten.

Function
REQ-014 SHALL store accepted classes in a HISTORY_DEPTH-entry ring buffer with a write pointer wrapping HISTORY_DEPTH-1 -> 0 and a fill count saturating at HISTORY_DEPTH.
REQ-015 SHALL keep one vote counter per class, width $clog2(HISTORY_DEPTH+1); sum of counters always equals fill count.
REQ-016 SHALL, on accept while not full, increment the counter of class_i; while full, also decrement the counter of the evicted entry; if the evicted class equals class_i, counters stay unchanged.
REQ-017 SHALL discard inp_valid_i with class_i >= NUM_CLASSES with no state change.
REQ-018 SHALL select the winner from the registered counters as the highest count, lowest index on ties.
REQ-019 SHALL have fixed latency: input accepted at edge N updates counters; winner is evaluated in cycle N+1; out_valid_o rises after edge N+1 (2 cycles input-to-output).
REQ-020 SHALL issue a decision only when winner count >= MIN_VOTES; otherwise it SHALL issue nothing for that frame.
REQ-021 SHALL hold class_o/votes_o stable while out_valid_o && !out_ready_i.
REQ-022 SHALL, if a new decision arrives while the held one is untransferred, overwrite it, keep out_valid_o high, and increment overrun_o (saturating at 255).
REQ-023 SHALL, on transfer with a simultaneous new decision, load the new one with out_valid_o staying high and no overrun.
REQ-024 SHALL, on transfer without a new decision, deassert out_valid_o on the next cycle.
REQ-025 SHALL make clear_i zero the counters, fill count and write pointer and cancel any in-flight decision; the output register and overrun_o SHALL be unaffected; clear_i wins over a simultaneous inp_valid_i, which is dropped.
REQ-026 SHALL accept back-to-back inp_valid_i every cycle.

Reset
REQ-027 SHALL, while reset_ni is low, force class_o=0, votes_o=0, out_valid_o=0, overrun_o=0, all counters, fill count, write pointer and pipeline flags to 0, independent of clk_i.
REQ-028 SHALL discard any in-flight decision when reset asserts mid-operation; the first input after release behaves as on an empty window.

Configuration
REQ-029 SHALL support macro VOTE_CHANGE_ONLY_EN: when defined, a decision is issued only if its class differs from the last issued class (a register reset to "none", also cleared by clear_i); when undefined, every qualifying frame issues a decision.

Verification
REQ-030 SHALL test: MIN_VOTES=3; classes 4,4,4 one per cycle, out_ready_i=1 -> first out_valid_o 2 cycles after third input, class_o=4, votes_o=3.
REQ-031 SHALL test: fill window with 8x class 2, then 5x class 7 -> votes_o goes 2:7,6,5,4 then 7:5 (7 wins at 5 vs 3); counter sum always 8.
REQ-032 SHALL test a tie: window 4x class 1, 4x class 6 -> class_o=1, votes_o=4.
REQ-033 SHALL test: out_ready_i=0, three qualifying decisions -> out_valid_o held, class_o shows the latest, overrun_o=2; raise ready -> one transfer, out_valid_o drops the next cycle.
REQ-034 SHALL test: clear_i together with inp_valid_i (class 3) after 5x class 3 -> no further decision until 3 new inputs; class_i=12 is ignored.
REQ-035 SHALL test: with VOTE_CHANGE_ONLY_EN, 10x class 5 -> exactly one decision issued; then reset_ni low mid-stream -> all outputs 0 asynchronously.
